operand_read_stage: RTL and testbench

- Register-read pipeline stage between decode and execute.
- Accepts one decoded instruction per cycle and drives the register-file read ports.
- Captures operands with write-back write-through bypass.
- Holds the result in a valid/ready pipeline register whose addresses and operands feed the execute-side forwarding logic. Detects load-use hazards and inserts exactly one bubble; supports branch flush.

---
 rtl/operand_read_stage_if.sv | 53 +++++
 rtl/operand_read_stage.sv | 92 +++++++++
 tb/tb_operand_read_stage.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_read_stage_if.sv
// Decode-side, register-file, write-back, hazard and execute-side signals of the operand read stage.
interface operand_read_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned OP_W   = 7,
  parameter int unsigned CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_opcode;
  logic [ADDR_W-1:0] in_dest;
  logic [ADDR_W-1:0] in_src0;
  logic [ADDR_W-1:0] in_src1;
  logic              in_use0;
  logic              in_use1;
  logic [DATA_W-1:0] in_imm;
  logic [ADDR_W-1:0] rf_addr0;
  logic [ADDR_W-1:0] rf_addr1;
  logic [DATA_W-1:0] rf_data0;
  logic [DATA_W-1:0] rf_data1;
  logic              wb_write_en;
  logic [ADDR_W-1:0] wb_destination;
  logic [DATA_W-1:0] wb_result;
  logic              exec_is_load;
  logic [ADDR_W-1:0] exec_destination;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   out_opcode;
  logic [ADDR_W-1:0] out_dest;
  logic [ADDR_W-1:0] read_address0;
  logic [ADDR_W-1:0] read_address1;
  logic [DATA_W-1:0] read_operand0;
  logic [DATA_W-1:0] read_operand1;
  logic [DATA_W-1:0] out_imm;
  logic [CNT_W-1:0]  stall_count;

  modport slave (
    input  in_valid, in_opcode, in_dest, in_src0, in_src1, in_use0, in_use1, in_imm,
           rf_data0, rf_data1, wb_write_en, wb_destination, wb_result,
           exec_is_load, exec_destination, flush, out_ready,
    output in_ready, rf_addr0, rf_addr1, out_valid, out_opcode, out_dest,
           read_address0, read_address1, read_operand0, read_operand1, out_imm, stall_count
  );

  modport master (
    output in_valid, in_opcode, in_dest, in_src0, in_src1, in_use0, in_use1, in_imm,
           rf_data0, rf_data1, wb_write_en, wb_destination, wb_result,
           exec_is_load, exec_destination, flush, out_ready,
    input  in_ready, rf_addr0, rf_addr1, out_valid, out_opcode, out_dest,
           read_address0, read_address1, read_operand0, read_operand1, out_imm, stall_count
  );
endinterface

// File: rtl/operand_read_stage.sv
// Register-read stage: reads GPRs with write-back write-through, inserts one bubble per load-use hazard.
module operand_read_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned OP_W   = 7,
  parameter int unsigned CNT_W  = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  operand_read_stage_if.slave bus
);
  typedef enum logic {RUN, BUBBLE} state_e;

  state_e            state_q;
  logic              out_valid_q;
  logic [OP_W-1:0]   opcode_q;
  logic [ADDR_W-1:0] dest_q;
  logic [ADDR_W-1:0] addr0_q;
  logic [ADDR_W-1:0] addr1_q;
  logic [DATA_W-1:0] opnd0_q;
  logic [DATA_W-1:0] opnd1_q;
  logic [DATA_W-1:0] imm_q;
  logic [CNT_W-1:0]  stall_q;

  logic              advance;
  logic              hazard;
  logic              in_ready;
  logic              accept;
  logic [DATA_W-1:0] opnd0_d;
  logic [DATA_W-1:0] opnd1_d;
  logic [CNT_W-1:0]  stall_d;

  always_comb begin
    advance  = ~out_valid_q | bus.out_ready;
    hazard   = bus.in_valid & bus.exec_is_load &
               ((bus.in_use0 & (bus.in_src0 == bus.exec_destination)) |
                (bus.in_use1 & (bus.in_src1 == bus.exec_destination)));
    // Once the bubble is paid the load sits in write-back, so the stall is not re-evaluated.
    in_ready = (state_q == RUN) ? (advance & ~hazard) : advance;
    accept   = bus.in_valid & in_ready & ~bus.flush;
    opnd0_d  = (bus.wb_write_en && (bus.wb_destination == bus.in_src0)) ? bus.wb_result : bus.rf_data0;
    opnd1_d  = (bus.wb_write_en && (bus.wb_destination == bus.in_src1)) ? bus.wb_result : bus.rf_data1;
    stall_d  = (stall_q == '1) ? stall_q : stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      dest_q      <= '0;
      addr0_q     <= '0;
      addr1_q     <= '0;
      opnd0_q     <= '0;
      opnd1_q     <= '0;
      imm_q       <= '0;
      stall_q     <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
      state_q     <= RUN;
    end else if ((state_q == RUN) && advance && hazard) begin
      out_valid_q <= 1'b0;
      stall_q     <= stall_d;
      state_q     <= BUBBLE;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      opcode_q    <= bus.in_opcode;
      dest_q      <= bus.in_dest;
      addr0_q     <= bus.in_src0;
      addr1_q     <= bus.in_src1;
      opnd0_q     <= opnd0_d;
      opnd1_q     <= opnd1_d;
      imm_q       <= bus.in_imm;
      state_q     <= RUN;
    end else if (advance) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.rf_addr0      = bus.in_src0;
  assign bus.rf_addr1      = bus.in_src1;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_opcode    = opcode_q;
  assign bus.out_dest      = dest_q;
  assign bus.read_address0 = addr0_q;
  assign bus.read_address1 = addr1_q;
  assign bus.read_operand0 = opnd0_q;
  assign bus.read_operand1 = opnd1_q;
  assign bus.out_imm       = imm_q;
  assign bus.stall_count   = stall_q;
endmodule

// File: tb/tb_operand_read_stage.sv
// Self-checking bench for operand_read_stage: directed vectors, corner sequences and a random run against a model.
module tb_operand_read_stage;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 3;
  localparam int OP_W    = 7;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_read_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W), .CNT_W(CNT_W)) bus();

  operand_read_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what execute should see, plus whether the waiting instruction already paid its bubble.
  logic              m_valid, m_paid, took;
  logic [OP_W-1:0]   m_op;
  logic [ADDR_W-1:0] m_dest, m_a0, m_a1;
  logic [DATA_W-1:0] m_o0, m_o1, m_imm;
  int                m_cnt;

  typedef struct {
    logic [ADDR_W-1:0] src0, src1;
    logic              use1;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_res, rf0, rf1;
    logic [DATA_W-1:0] exp0, exp1;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_valid = 0; m_paid = 0; took = 0;
    m_op = '0; m_dest = '0; m_a0 = '0; m_a1 = '0;
    m_o0 = '0; m_o1 = '0; m_imm = '0; m_cnt = 0;
  endtask

  function automatic logic m_hazard();
    return bus.in_valid && bus.exec_is_load &&
           ((bus.in_use0 && bus.in_src0 == bus.exec_destination) ||
            (bus.in_use1 && bus.in_src1 == bus.exec_destination));
  endfunction

  function automatic logic m_ready();
    logic room;
    room = !m_valid || bus.out_ready;
    return room && (m_paid || !m_hazard());
  endfunction

  task automatic tick();
    logic room, bub, take;
    logic [DATA_W-1:0] b0, b1;
    room = !m_valid || bus.out_ready;
    bub  = !bus.flush && room && m_hazard() && !m_paid;
    take = !bus.flush && bus.in_valid && m_ready();
    b0 = (bus.wb_write_en && bus.wb_destination == bus.in_src0) ? bus.wb_result : bus.rf_data0;
    b1 = (bus.wb_write_en && bus.wb_destination == bus.in_src1) ? bus.wb_result : bus.rf_data1;
    took = take;
    @(posedge clk);
    if (bus.flush) begin
      m_valid = 0; m_paid = 0;
    end else if (bub) begin
      m_valid = 0; m_paid = 1;
      if (m_cnt < CNT_MAX) m_cnt++;
    end else if (take) begin
      m_valid = 1; m_paid = 0;
      m_op = bus.in_opcode; m_dest = bus.in_dest; m_imm = bus.in_imm;
      m_a0 = bus.in_src0; m_a1 = bus.in_src1; m_o0 = b0; m_o1 = b1;
    end else if (room) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic chk_ready(input string name, input logic exp);
    #1;
    check(name, bus.in_ready, exp);
  endtask

  task automatic check_model();
    check("mdl_valid", bus.out_valid, m_valid);
    check("mdl_stall", bus.stall_count, m_cnt);
    check("mdl_opcode", bus.out_opcode, m_op);
    check("mdl_dest", bus.out_dest, m_dest);
    check("mdl_addr0", bus.read_address0, m_a0);
    check("mdl_addr1", bus.read_address1, m_a1);
    check("mdl_opnd0", bus.read_operand0, m_o0);
    check("mdl_opnd1", bus.read_operand1, m_o1);
    check("mdl_imm", bus.out_imm, m_imm);
  endtask

  task automatic drive_idle();
    bus.in_valid = 0; bus.in_opcode = '0; bus.in_dest = '0; bus.in_src0 = '0; bus.in_src1 = '0;
    bus.in_use0 = 0; bus.in_use1 = 0; bus.in_imm = '0; bus.rf_data0 = '0; bus.rf_data1 = '0;
    bus.wb_write_en = 0; bus.wb_destination = '0; bus.wb_result = '0;
    bus.exec_is_load = 0; bus.exec_destination = '0; bus.flush = 0; bus.out_ready = 1;
  endtask

  task automatic set_instr(input int op, input int s0, input int s1, input logic u0, input logic u1,
                           input logic [DATA_W-1:0] r0);
    bus.in_valid = 1; bus.in_opcode = OP_W'(op); bus.in_dest = ADDR_W'(op);
    bus.in_src0 = ADDR_W'(s0); bus.in_src1 = ADDR_W'(s1);
    bus.in_use0 = u0; bus.in_use1 = u1; bus.in_imm = DATA_W'(op * 3); bus.rf_data0 = r0;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{src0:2, src1:5, use1:1, wb_en:1, wb_dest:5, wb_res:'h99, rf0:'h22, rf1:'h11, exp0:'h22, exp1:'h99};
    vecs[1] = '{src0:2, src1:5, use1:1, wb_en:1, wb_dest:4, wb_res:'h99, rf0:'h22, rf1:'h11, exp0:'h22, exp1:'h11};
    vecs[2] = '{src0:4, src1:1, use1:1, wb_en:1, wb_dest:4, wb_res:'h77, rf0:'h33, rf1:'h44, exp0:'h77, exp1:'h44};
    vecs[3] = '{src0:6, src1:6, use1:1, wb_en:1, wb_dest:6, wb_res:'hAB, rf0:'h01, rf1:'h02, exp0:'hAB, exp1:'hAB};
    vecs[4] = '{src0:6, src1:6, use1:1, wb_en:0, wb_dest:6, wb_res:'hAB, rf0:'h01, rf1:'h02, exp0:'h01, exp1:'h02};
    vecs[5] = '{src0:0, src1:5, use1:0, wb_en:1, wb_dest:5, wb_res:'h5A, rf0:'h10, rf1:'h20, exp0:'h10, exp1:'h5A};

    drive_idle();
    m_reset();
    #12 rst_n = 1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_stall", bus.stall_count, 0);
    check("rst_opnd0", bus.read_operand0, 0);

    // Plain streaming
    for (int i = 0; i < 3; i++) begin
      set_instr(i + 1, 1, 2, 1, 1, DATA_W'('hA + i));
      tick();
      check("stream_valid", bus.out_valid, 1);
      check("stream_opnd0", bus.read_operand0, 'hA + i);
      check("stream_opcode", bus.out_opcode, i + 1);
    end
    bus.in_valid = 0;
    tick();
    check("stream_drain", bus.out_valid, 0);

    // Write-through bypass table
    for (int i = 0; i < 6; i++) begin
      set_instr(i + 8, vecs[i].src0, vecs[i].src1, 1, vecs[i].use1, vecs[i].rf0);
      bus.rf_data1 = vecs[i].rf1; bus.wb_write_en = vecs[i].wb_en;
      bus.wb_destination = vecs[i].wb_dest; bus.wb_result = vecs[i].wb_res;
      tick();
      check("byp_opnd0", bus.read_operand0, vecs[i].exp0);
      check("byp_opnd1", bus.read_operand1, vecs[i].exp1);
    end

    // Load-use: one bubble, then issue even though the load flag is still up
    drive_idle();
    set_instr(20, 3, 1, 1, 0, 'h55);
    bus.exec_is_load = 1; bus.exec_destination = 3;
    chk_ready("lu_ready_low", 0);
    tick();
    check("lu_bubble", bus.out_valid, 0);
    check("lu_stall1", bus.stall_count, 1);
    chk_ready("lu_ready_bubble", 1);
    tick();
    check("lu_issue", bus.out_valid, 1);
    check("lu_opnd0", bus.read_operand0, 'h55);
    set_instr(21, 3, 1, 0, 0, 'h66);
    chk_ready("lu_unused_ready", 1);
    tick();
    check("lu_unused_valid", bus.out_valid, 1);
    check("lu_unused_stall", bus.stall_count, 1);
    set_instr(22, 0, 3, 0, 1, 'h77);
    chk_ready("lu_b2b_ready", 0);
    tick();
    tick();
    check("lu_b2b_stall", bus.stall_count, 2);
    check("lu_b2b_valid", bus.out_valid, 1);

    // Backpressure
    drive_idle();
    set_instr(30, 1, 2, 1, 1, 'hAAA);
    tick();
    set_instr(31, 1, 2, 1, 1, 'hBBB);
    bus.out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      chk_ready("bp_ready", 0);
      tick();
      check("bp_valid", bus.out_valid, 1);
      check("bp_hold", bus.read_operand0, 'hAAA);
    end
    bus.out_ready = 1;
    chk_ready("bp_release", 1);
    tick();
    check("bp_next", bus.read_operand0, 'hBBB);

    // Flush beats a pending hazard, and resets the FSM out of BUBBLE
    set_instr(40, 3, 0, 1, 0, 'h1);
    bus.exec_is_load = 1; bus.exec_destination = 3; bus.flush = 1;
    tick();
    check("fl_valid", bus.out_valid, 0);
    check("fl_stall", bus.stall_count, 2);
    bus.flush = 0;
    chk_ready("fl_run_ready", 0);
    tick();
    check("fl_bubble_stall", bus.stall_count, 3);
    bus.flush = 1;
    tick();
    bus.flush = 0;
    chk_ready("fl_from_bubble", 0);
    tick();
    check("fl_rebubble", bus.stall_count, 4);

    // Saturation (counter narrowed so the bench stays short)
    for (int i = 0; i < 20; i++) begin
      tick();
      tick();
    end
    check("sat_stall", bus.stall_count, CNT_MAX);
    tick();
    check("sat_hold", bus.stall_count, CNT_MAX);

    // Reset mid-stream
    drive_idle();
    set_instr(50, 1, 2, 1, 1, 'h1234);
    tick();
    bus.in_valid = 0; bus.out_ready = 0;
    tick();
    check("mr_valid_pre", bus.out_valid, 1);
    check("mr_opnd_pre", bus.read_operand0, 'h1234);
    #2 rst_n = 0;
    #1;
    check("mr_valid", bus.out_valid, 0);
    check("mr_opnd0", bus.read_operand0, 0);
    check("mr_stall", bus.stall_count, 0);
    m_reset();
    #3 rst_n = 1;

    // Random run against the model; instruction is held until accepted
    drive_idle();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3000; i++) begin
      if (!bus.in_valid || took) begin
        bus.in_valid  = ($urandom_range(3) != 0);
        bus.in_opcode = OP_W'($urandom);
        bus.in_dest   = ADDR_W'($urandom);
        bus.in_src0   = ADDR_W'($urandom);
        bus.in_src1   = ADDR_W'($urandom);
        bus.in_use0   = 1'($urandom);
        bus.in_use1   = 1'($urandom);
        bus.in_imm    = $urandom;
      end
      bus.rf_data0 = $urandom; bus.rf_data1 = $urandom;
      bus.wb_write_en = 1'($urandom); bus.wb_destination = ADDR_W'($urandom); bus.wb_result = $urandom;
      bus.exec_is_load = 1'($urandom); bus.exec_destination = ADDR_W'($urandom);
      bus.flush = ($urandom_range(15) == 0);
      bus.out_ready = ($urandom_range(3) != 0);
      #1;
      check("rnd_in_ready", bus.in_ready, m_ready());
      check("rnd_rf_addr0", bus.rf_addr0, bus.in_src0);
      tick();
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
